// File: rtl/edge_magnitude_pkg.sv
// Shared definitions for the edge-detection output pipeline.
package edge_magnitude_pkg;

  localparam int unsigned PIXEL_SIZE_DEF = 12;
  localparam int unsigned CONV_SIZE_DEF  = PIXEL_SIZE_DEF + 4;

  // Unsigned output pixel and signed convolution word at the default width
  typedef logic        [PIXEL_SIZE_DEF-1:0] pixel_t;
  typedef logic signed [CONV_SIZE_DEF-1:0]  conv_t;

  localparam pixel_t PIXEL_MAX = '1;

endpackage

// File: rtl/edge_magnitude_position.sv
// Row/column tracker for the incoming pixel stream; produces the border
// and last-pixel flags for the pixel presented this cycle.
module frame_position_counter
  import edge_magnitude_pkg::*;
#(
  parameter int unsigned ROW_SIZE = 640,
  parameter int unsigned NUM_ROWS = 480
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  input  logic sof,
  output logic border,
  output logic last
);

  localparam int unsigned COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  logic [COL_W-1:0] col, cur_col;
  logic [ROW_W-1:0] row, cur_row;

  // Position of the current pixel: sof forces row 0, col 0
  always_comb begin
    cur_col = sof ? '0 : col;
    cur_row = sof ? '0 : row;
    border  = (32'(cur_row) < 32'd2) || (32'(cur_col) < 32'd2);
    last    = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  end

  // Advance the counters one position per valid pixel, wrapping at row/frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

endmodule

// File: rtl/edge_magnitude.sv
// L1 gradient magnitude |gx|+|gy| with saturation and frame-border blanking.
// Two-stage pipeline, no backpressure; valid travels with its data.
module edge_magnitude
  import edge_magnitude_pkg::*;
#(
  parameter int unsigned PIXEL_SIZE = PIXEL_SIZE_DEF,
  parameter int unsigned ROW_SIZE   = 640,
  parameter int unsigned NUM_ROWS   = 480
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [PIXEL_SIZE+3:0]   gx,
  input  logic signed [PIXEL_SIZE+3:0]   gy,
  input  logic                           valid_in,
  input  logic                           sof,
  output logic        [PIXEL_SIZE-1:0]   out_pixel,
  output logic                           valid_out,
  output logic                           eof_out
);

  localparam int unsigned CW = PIXEL_SIZE + 4;

  logic          pos_border, pos_last;
  logic [CW-1:0] abs_gx, abs_gy;

  logic          s1_valid, s1_border, s1_last;
  logic [CW-1:0] s1_abs_gx, s1_abs_gy;

  logic [CW:0]           sum;
  logic [PIXEL_SIZE-1:0] mag;

  frame_position_counter #(
    .ROW_SIZE (ROW_SIZE),
    .NUM_ROWS (NUM_ROWS)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .sof      (sof),
    .border   (pos_border),
    .last     (pos_last)
  );

  // Absolute values as unsigned: the most negative input maps to 2^(CW-1) exactly
  always_comb begin
    abs_gx = gx[CW-1] ? (~$unsigned(gx) + 1'b1) : $unsigned(gx);
    abs_gy = gy[CW-1] ? (~$unsigned(gy) + 1'b1) : $unsigned(gy);
  end

  // Stage 1: capture magnitudes and position flags for each valid pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_abs_gx <= '0;
      s1_abs_gy <= '0;
      s1_border <= 1'b0;
      s1_last   <= 1'b0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_abs_gx <= abs_gx;
        s1_abs_gy <= abs_gy;
        s1_border <= pos_border;
        s1_last   <= pos_last;
      end
    end
  end

  // Sum with one bit of headroom, then saturate or blank
  always_comb begin
    sum = {1'b0, s1_abs_gx} + {1'b0, s1_abs_gy};
    if (s1_border)
      mag = '0;
    else if (|sum[CW:PIXEL_SIZE])
      mag = '1;
    else
      mag = sum[PIXEL_SIZE-1:0];
  end

  // Stage 2: output register; out_pixel holds across idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pixel <= '0;
      valid_out <= 1'b0;
      eof_out   <= 1'b0;
    end else begin
      valid_out <= s1_valid;
      eof_out   <= s1_valid & s1_last;
      if (s1_valid)
        out_pixel <= mag;
    end
  end

endmodule

// File: tb/tb_edge_magnitude.sv
// Directed bench for edge_magnitude using a reduced frame geometry.
module tb_edge_magnitude;
  import edge_magnitude_pkg::*;

  localparam int RS = 16;
  localparam int NR = 8;
  localparam int FRAME = RS * NR;

  typedef struct {
    int     due;
    pixel_t pix;
    logic   eof;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  conv_t  gx = '0, gy = '0;
  logic   valid_in = 1'b0, sof = 1'b0;
  pixel_t out_pixel;
  logic   valid_out, eof_out;

  int     cyc = 0;
  int     tests = 0, fails = 0;
  int     mr = 0, mc = 0;
  int     nvalid = 0, neof = 0, eof_idx = -1;
  pixel_t last_out = '0;
  exp_t   q[$];
  exp_t   e;

  edge_magnitude #(
    .PIXEL_SIZE (12),
    .ROW_SIZE   (RS),
    .NUM_ROWS   (NR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gx        (gx),
    .gy        (gy),
    .valid_in  (valid_in),
    .sof       (sof),
    .out_pixel (out_pixel),
    .valid_out (valid_out),
    .eof_out   (eof_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of input; valid pixels push their expected result
  task automatic step(input logic v, input logic s, input int gxv, input int gyv);
    int ax, ay, sum;
    exp_t x;
    gx = conv_t'(gxv);
    gy = conv_t'(gyv);
    valid_in = v;
    sof = s;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      ax = (gxv < 0) ? -gxv : gxv;
      ay = (gyv < 0) ? -gyv : gyv;
      sum = ax + ay;
      x.due = cyc + 2;
      x.eof = (mr == NR - 1) && (mc == RS - 1);
      if (mr < 2 || mc < 2)
        x.pix = '0;
      else if (sum > int'(PIXEL_MAX))
        x.pix = PIXEL_MAX;
      else
        x.pix = pixel_t'(sum);
      q.push_back(x);
      mc++;
      if (mc == RS) begin
        mc = 0;
        mr++;
        if (mr == NR) mr = 0;
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sof = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    tests++;
    assert (q.size() == 0)
      else begin fails++; $error("FAIL drain_timeout: pending=%0d required=0", q.size()); end
  endtask

  task automatic clear_counts();
    nvalid = 0;
    neof = 0;
    eof_idx = -1;
  endtask

  // Scoreboard: compare each valid_out against the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        tests++;
        assert (q.size() != 0)
          else begin fails++; $error("FAIL unexpected_valid: out_pixel=%0d required=no output", out_pixel); end
        if (q.size() != 0) begin
          e = q.pop_front();
          tests++;
          assert (cyc === e.due)
            else begin fails++; $error("FAIL latency: cycle=%0d required=%0d", cyc, e.due); end
          tests++;
          assert (out_pixel === e.pix)
            else begin fails++; $error("FAIL pixel: out_pixel=%0d required=%0d", out_pixel, e.pix); end
          tests++;
          assert (eof_out === e.eof)
            else begin fails++; $error("FAIL eof: eof_out=%0b required=%0b", eof_out, e.eof); end
        end
        nvalid++;
        if (eof_out) begin
          neof++;
          eof_idx = nvalid;
        end
        last_out = out_pixel;
      end else begin
        tests++;
        assert (out_pixel === last_out)
          else begin fails++; $error("FAIL idle_hold: out_pixel=%0d required=%0d", out_pixel, last_out); end
        tests++;
        assert (eof_out === 1'b0)
          else begin fails++; $error("FAIL idle_eof: eof_out=%0b required=0", eof_out); end
        if (q.size() != 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          tests++;
          assert (1'b0)
            else begin fails++; $error("FAIL missing_valid: valid_out=0 required=1 at cycle %0d", e.due); end
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    tests++;
    assert (valid_out === 1'b0) else begin fails++; $error("FAIL rst_valid: got=%0b required=0", valid_out); end
    tests++;
    assert (out_pixel === '0) else begin fails++; $error("FAIL rst_pixel: got=%0d required=0", out_pixel); end
    tests++;
    assert (eof_out === 1'b0) else begin fails++; $error("FAIL rst_eof: got=%0b required=0", eof_out); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Border masking up to row 2, col 2 (150 there)
    step(1'b1, 1'b1, 100, -50);
    for (int i = 1; i <= 2 * RS + 2; i++) step(1'b1, 1'b0, 100, -50);

    // Interior: saturation and sign handling, with a stray sof while idle
    step(1'b1, 1'b0, 3000, 2000);
    step(1'b1, 1'b0, -32768, -32768);
    step(1'b0, 1'b1, 0, 0);
    step(1'b1, 1'b0, -7, 0);
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 4095, 0);
    step(1'b1, 1'b0, 4096, 0);
    drain();

    // Full frame with random idle gaps
    clear_counts();
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, (i == 0), $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 0, 0);
    end
    drain();
    tests++;
    assert (nvalid == FRAME) else begin fails++; $error("FAIL frame_count: got=%0d required=%0d", nvalid, FRAME); end
    tests++;
    assert (neof == 1) else begin fails++; $error("FAIL frame_eof_count: got=%0d required=1", neof); end
    tests++;
    assert (eof_idx == FRAME) else begin fails++; $error("FAIL frame_eof_pos: got=%0d required=%0d", eof_idx, FRAME); end

    // Next sof restarts masking; then a mid-frame sof
    for (int i = 0; i < 20; i++) step(1'b1, (i == 0), 2000, 1000);
    drain();
    clear_counts();
    for (int i = 0; i < FRAME; i++) step(1'b1, (i == 0), 1500, -1500);
    drain();
    tests++;
    assert (neof == 1) else begin fails++; $error("FAIL midsof_eof_count: got=%0d required=1", neof); end
    tests++;
    assert (eof_idx == FRAME) else begin fails++; $error("FAIL midsof_eof_pos: got=%0d required=%0d", eof_idx, FRAME); end

    // Reset with two interior pixels in flight
    for (int i = 0; i < 2 * RS + 2; i++) step(1'b1, 1'b0, 300, 300);
    drain();
    step(1'b1, 1'b0, 1234, 1);
    step(1'b1, 1'b0, 777, 2);
    rst_n = 1'b0;
    q.delete();
    mr = 0;
    mc = 0;
    last_out = '0;
    #1;
    tests++;
    assert (valid_out === 1'b0) else begin fails++; $error("FAIL midrst_valid: got=%0b required=0", valid_out); end
    tests++;
    assert (out_pixel === '0) else begin fails++; $error("FAIL midrst_pixel: got=%0d required=0", out_pixel); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 500, 500);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
